// File: rtl/ioctl_loader.sv
// ioctl download front-end: captures one ioctl_index stream into an addr/data FIFO and
// drains it to a req/ack memory write port. Optional checksum: define LOADER_CHECKSUM_EN.
module ioctl_loader #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned ADDR_W     = 18,
    parameter logic [7:0]  INDEX      = 8'h01,
    parameter logic [24:0] OFFSET     = 25'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [24:0]       byte_count,
    output logic [15:0]       checksum
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    // Two below full: one slot for the write already in flight when wait is seen.
    localparam logic [CW-1:0] WAIT_THR = CW'(DEPTH - 2);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              mem_req_q, mem_req_d;
    logic              wait_q, wait_d;
    logic              overflow_q, overflow_d;
    logic [24:0]       byte_count_q, byte_count_d;

    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [7:0]        fifo_data_q [DEPTH];

    logic              sel_match;
    logic              accept;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic              load_start;
    logic [24:0]       addr_sum;
    logic [ADDR_W-1:0] entry_addr;
    logic              unused_addr_sum;

    always_comb begin
        sel_match  = (ioctl_index == INDEX);
        accept     = ioctl_wr & ioctl_download & sel_match & (state_q == StLoad);
        full       = (count_q == FULL_CNT);
        pop        = mem_req_q & mem_ack;
        // A full FIFO still takes a byte when the head leaves on the same edge.
        push       = accept & (~full | pop);
        drop       = accept & full & ~pop;
        addr_sum   = ioctl_addr + OFFSET;
        entry_addr = addr_sum[ADDR_W-1:0];
    end

    assign unused_addr_sum = ^addr_sum;

    // Control FSM
    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ioctl_download && sel_match) begin
                    state_d    = StLoad;
                    load_start = 1'b1;
                end
            end
            StLoad: begin
                if (!ioctl_download) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if ((count_q == '0) && !mem_req_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FIFO pointers, occupancy and status
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        byte_count_d = byte_count_q;
        overflow_d   = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (load_start) begin
            byte_count_d = '0;
            overflow_d   = 1'b0;
        end else begin
            if (push) begin
                byte_count_d = byte_count_q + 25'd1;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end

        mem_req_d = (count_d != '0);
        wait_d    = (count_q >= WAIT_THR) | ((state_q == StDrain) & ioctl_download);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_req_q    <= 1'b0;
            wait_q       <= 1'b0;
            overflow_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_req_q    <= mem_req_d;
            wait_q       <= wait_d;
            overflow_q   <= overflow_d;
            byte_count_q <= byte_count_d;
        end
    end

    // Storage needs no reset: only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= entry_addr;
            fifo_data_q[wr_ptr_q] <= ioctl_dout;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (load_start) begin
            checksum_d = '0;
        end else if (push) begin
            checksum_d = checksum_q + {8'h00, ioctl_dout};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign ioctl_wait = wait_q;
    assign mem_req    = mem_req_q;
    // Head is gated so the port reads zero whenever no request is pending.
    assign mem_addr   = mem_req_q ? fifo_addr_q[rd_ptr_q] : '0;
    assign mem_data   = mem_req_q ? fifo_data_q[rd_ptr_q] : '0;
    assign busy       = (state_q == StLoad) || (state_q == StDrain);
    assign done       = (state_q == StDone);
    assign overflow   = overflow_q;
    assign byte_count = byte_count_q;

endmodule
